// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and load/store (MEM first).
// Define MEMCTRL_IBUF_EN to add a one-entry instruction buffer that short-circuits repeated fetches.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    // state | meaning
    // IDLE  | waiting for a request, MEM before IF
    // RD    | issuing read addresses and capturing bytes one edge later
    // WR    | driving one write byte per cycle
    // ACK   | done pulse for one cycle, requests ignored
    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    state_t      state_q, state_d;
    logic        is_if_q;
    logic [2:0]  step_q, len_q, mem_len;
    logic [31:0] rbuf_q, rword, fetch_word;
    logic [23:0] wsh_q;
    logic        if_done_q, mem_done_q;
    logic        accept_mem, accept_if, abort_if, rd_last, wr_last, rd_end;
    logic        hit_accept;
    logic [1:0]  cap_idx;

`ifdef MEMCTRL_IBUF_EN
    logic        ibuf_valid, hit_q;
    logic [29:0] ibuf_tag, fetch_tag_q;
    logic [31:0] ibuf_inst;

    assign hit_accept = accept_if && ibuf_valid && (ibuf_tag == if_addr[31:2]);
    // A buffer hit spends one RD cycle without touching the RAM, then acks.
    assign rd_end     = hit_q || (step_q == len_q);
    assign fetch_word = hit_q ? ibuf_inst : rword;

    always_ff @(posedge clk) begin
        if (rst) begin
            ibuf_valid  <= 1'b0;
            hit_q       <= 1'b0;
            ibuf_tag    <= '0;
            fetch_tag_q <= '0;
            ibuf_inst   <= '0;
        end else begin
            if (accept_if) begin
                hit_q       <= hit_accept;
                fetch_tag_q <= if_addr[31:2];
            end else if (accept_mem) begin
                hit_q <= 1'b0;
            end
            if (accept_mem && mem_we && (ibuf_tag == mem_addr[31:2])) begin
                ibuf_valid <= 1'b0;
            end else if (rd_last && is_if_q && !hit_q) begin
                ibuf_valid <= 1'b1;
                ibuf_tag   <= fetch_tag_q;
                ibuf_inst  <= rword;
            end
        end
    end
`else
    assign hit_accept = 1'b0;
    assign rd_end     = (step_q == len_q);
    assign fetch_word = rword;
`endif

    always_comb begin
        case (mem_sel)
            2'b00:   mem_len = 3'd1;
            2'b01:   mem_len = 3'd2;
            default: mem_len = 3'd4;
        endcase
    end

    // Byte step-1 arrives on ram_din while step_q = step.
    assign cap_idx = step_q[1:0] - 2'd1;

    always_comb begin
        rword = rbuf_q;
        if (step_q != 3'd0) rword[{cap_idx, 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        state_d    = state_q;
        accept_mem = 1'b0;
        accept_if  = 1'b0;
        abort_if   = 1'b0;
        rd_last    = 1'b0;
        wr_last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    accept_mem = 1'b1;
                    state_d    = mem_we ? WR : RD;
                end else if (if_req) begin
                    accept_if = 1'b1;
                    state_d   = RD;
                end
            end
            RD: begin
                if (is_if_q && if_cancel) begin
                    abort_if = 1'b1;
                    state_d  = IDLE;
                end else if (rd_end) begin
                    rd_last = 1'b1;
                    state_d = ACK;
                end
            end
            WR: begin
                if (step_q + 3'd1 == len_q) begin
                    wr_last = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_if_q    <= 1'b0;
            step_q     <= '0;
            len_q      <= '0;
            rbuf_q     <= '0;
            wsh_q      <= '0;
            ram_addr   <= '0;
            ram_wr     <= 1'b0;
            ram_dout   <= '0;
            if_inst    <= '0;
            mem_rdata  <= '0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            if (accept_mem || accept_if) begin
                is_if_q <= accept_if;
                step_q  <= '0;
                rbuf_q  <= '0;
                len_q   <= accept_if ? 3'd4 : mem_len;
                if (!hit_accept) ram_addr <= accept_if ? if_addr : mem_addr;
                if (accept_mem && mem_we) begin
                    ram_wr   <= 1'b1;
                    ram_dout <= mem_wdata[7:0];
                    wsh_q    <= mem_wdata[31:8];
                end
            end
            if (state_q == RD && !abort_if) begin
                step_q <= step_q + 3'd1;
                if (step_q != 3'd0) rbuf_q <= rword;
                if (rd_last) begin
                    if (is_if_q) begin
                        if_inst   <= fetch_word;
                        if_done_q <= 1'b1;
                    end else begin
                        mem_rdata  <= rword;
                        mem_done_q <= 1'b1;
                    end
                end else if (step_q + 3'd1 < len_q) begin
                    ram_addr <= ram_addr + 32'd1;
                end
            end
            if (wr_last) begin
                ram_wr     <= 1'b0;
                mem_done_q <= 1'b1;
            end else if (state_q == WR) begin
                step_q   <= step_q + 3'd1;
                ram_addr <= ram_addr + 32'd1;
                ram_dout <= wsh_q[7:0];
                wsh_q    <= {8'd0, wsh_q[23:8]};
            end
        end
    end

    // A redirect arriving during the fetch ack suppresses the pulse.
    assign if_done      = if_done_q && !if_cancel;
    assign mem_done     = mem_done_q;
    assign stallreq_if  = if_req && !if_done_q;
    assign stallreq_mem = mem_req && !mem_done_q;

endmodule
